ex_case_unit: RTL and testbench

- Registered, address-decoded data-transform block built around one case statement.
- Each clock cycle, the 8-bit operation code on i_addr selects one transform of the 10-bit i_data.
- The selected result is registered to o_data, with a one-cycle o_dv strobe.
- Sits behind a simple write-style bus (data plus address each cycle, no handshake); also contains an internal 8-bit accumulator.

---
 rtl/ex_case_unit.sv | 93 +++++++++
 tb/tb_ex_case_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ex_case_unit.sv
// Registered, address-decoded transform unit: i_addr picks one operation on i_data,
// the result lands in o_data one edge later with a single-cycle o_dv strobe.
module ex_case_unit #(
  parameter logic [7:0] ACC_INIT = 8'h00,
  parameter logic [7:0] DATA_RST = 8'h00
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [9:0] i_data,
  input  logic [7:0] i_addr,
  output logic       o_dv,
  output logic [7:0] o_data
);

  logic [7:0] r_data;
  logic       r_dv;
  logic [7:0] r_acc;

  logic [7:0] w_d;
  logic [7:0] w_pop;
  logic [7:0] w_prio;
  logic [7:0] w_rev;
  logic [7:0] w_sum;
  logic       w_valid;
  logic [7:0] w_result;
  logic [7:0] w_accNext;

  assign w_d   = i_data[7:0];
  assign w_sum = r_acc + w_d;

  // Bit-level helpers over the full 10-bit operand (popcount, highest set bit)
  always_comb begin
    w_pop  = 8'h00;
    w_prio = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      w_pop = w_pop + {7'b0, i_data[k]};
      if (i_data[k]) w_prio = 8'(k);
    end
  end

  always_comb begin
    w_rev = 8'h00;
    for (int k = 0; k < 8; k++) w_rev[k] = w_d[7-k];
  end

  // Idle and out-of-range codes fall to default: no strobe, o_data and acc hold
  always_comb begin
    w_valid   = 1'b1;
    w_result  = r_data;
    w_accNext = r_acc;
    case (i_addr)
      8'h01: w_result = w_d;
      8'h02: w_result = ~w_d;
      8'h03: w_result = i_data[9:2];
      8'h04: w_result = {w_d[3:0], w_d[7:4]};
      8'h05: w_result = w_rev;
      8'h06: w_result = (i_data[9:8] != 2'b00) ? 8'hFF : w_d;
      8'h07: w_result = w_d + 8'h01;
      8'h08: w_result = w_d - 8'h01;
      8'h09: w_result = w_pop;
      8'h0A: w_result = w_prio;
      8'h0B: w_result = {7'b0, ^i_data};
      8'h0C: w_result = w_d ^ (w_d >> 1);
      8'h0D: begin
        w_result  = w_sum;
        w_accNext = w_sum;
      end
      8'h0E: begin
        w_result  = 8'h00;
        w_accNext = 8'h00;
      end
      8'h0F: w_result = r_acc;
      default: w_valid = 1'b0;
    endcase
  end

  // rst_n is active-high despite its name
  always_ff @(posedge sclk or posedge rst_n) begin
    if (rst_n) begin
      r_dv   <= 1'b0;
      r_data <= DATA_RST;
      r_acc  <= ACC_INIT;
    end else begin
      r_dv   <= w_valid;
      r_data <= w_result;
      r_acc  <= w_accNext;
    end
  end

  assign o_dv   = r_dv;
  assign o_data = r_data;

endmodule

// File: tb/tb_ex_case_unit.sv
// Directed self-checking bench for ex_case_unit with hand-computed expected values.
module tb_ex_case_unit;

  logic       sclk;
  logic       rst_n;
  logic [9:0] i_data;
  logic [7:0] i_addr;
  logic       o_dv;
  logic [7:0] o_data;

  int checkCount = 0;
  int errorCount = 0;

  ex_case_unit #(.ACC_INIT(8'h00), .DATA_RST(8'h00)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .i_data(i_data),
    .i_addr(i_addr),
    .o_dv  (o_dv),
    .o_data(o_data)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
    end
  endtask

  // Drive one bus cycle, then sample 1 ns after the capturing edge
  task automatic applyStimulus(input logic [7:0] addr, input logic [9:0] data);
    i_addr = addr;
    i_data = data;
    @(posedge sclk);
    #1;
  endtask

  task automatic runVec(input string tag, input logic [7:0] addr, input logic [9:0] data,
                        input logic dvExp, input logic [7:0] dataExp);
    applyStimulus(addr, data);
    checkOutput({tag, ".dv"}, {7'b0, o_dv}, {7'b0, dvExp});
    checkOutput({tag, ".data"}, o_data, dataExp);
  endtask

  initial begin
    rst_n  = 1'b1;
    i_addr = 8'h00;
    i_data = 10'h000;

    // Reset held 200 ns with random bus traffic
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'($urandom_range(1, 15)), 10'($urandom));
      checkOutput("rstHold.dv", {7'b0, o_dv}, 8'h00);
      checkOutput("rstHold.data", o_data, 8'h00);
    end
    i_addr = 8'h00;
    i_data = 10'h000;
    rst_n  = 1'b0;

    runVec("stream0", 8'h00, 10'h000, 1'b0, 8'h00);
    runVec("stream1", 8'h01, 10'h001, 1'b1, 8'h01);
    runVec("stream2", 8'h02, 10'h002, 1'b1, 8'hFD);
    runVec("stream3", 8'h03, 10'h003, 1'b1, 8'h00);
    runVec("stream4", 8'h00, 10'h000, 1'b0, 8'h00);

    runVec("satMax",   8'h06, 10'h3FF, 1'b1, 8'hFF);
    runVec("satEdge",  8'h06, 10'h0FF, 1'b1, 8'hFF);
    runVec("satPass",  8'h06, 10'h080, 1'b1, 8'h80);
    runVec("satBit8",  8'h06, 10'h112, 1'b1, 8'hFF);
    runVec("incWrap",  8'h07, 10'h0FF, 1'b1, 8'h00);
    runVec("incMid",   8'h07, 10'h07F, 1'b1, 8'h80);
    runVec("decWrap",  8'h08, 10'h000, 1'b1, 8'hFF);
    runVec("prioZero", 8'h0A, 10'h000, 1'b1, 8'hFF);
    runVec("prioTop",  8'h0A, 10'h200, 1'b1, 8'h09);
    runVec("prioLow",  8'h0A, 10'h005, 1'b1, 8'h02);
    runVec("popAll",   8'h09, 10'h3FF, 1'b1, 8'h0A);
    runVec("popAlt",   8'h09, 10'h155, 1'b1, 8'h05);
    runVec("upper",    8'h03, 10'h3FC, 1'b1, 8'hFF);
    runVec("swap",     8'h04, 10'h03C, 1'b1, 8'hC3);
    runVec("swap2",    8'h04, 10'h012, 1'b1, 8'h21);
    runVec("reverse",  8'h05, 10'h001, 1'b1, 8'h80);
    runVec("reverse2", 8'h05, 10'h0B1, 1'b1, 8'h8D);
    runVec("parEven",  8'h0B, 10'h3FF, 1'b1, 8'h00);
    runVec("parOdd",   8'h0B, 10'h200, 1'b1, 8'h01);
    runVec("gray",     8'h0C, 10'h0B4, 1'b1, 8'hEE);
    runVec("invert",   8'h02, 10'h35A, 1'b1, 8'hA5);

    runVec("acc1",     8'h0D, 10'h080, 1'b1, 8'h80);
    runVec("acc2",     8'h0D, 10'h090, 1'b1, 8'h10);
    runVec("accRead",  8'h0F, 10'h3FF, 1'b1, 8'h10);
    runVec("accClear", 8'h0E, 10'h055, 1'b1, 8'h00);
    runVec("accRead0", 8'h0F, 10'h000, 1'b1, 8'h00);

    runVec("accSet",   8'h0D, 10'h033, 1'b1, 8'h33);
    runVec("passA",    8'h01, 10'h05A, 1'b1, 8'h5A);
    runVec("inv10",    8'h10, 10'h077, 1'b0, 8'h5A);
    runVec("invFF",    8'hFF, 10'h012, 1'b0, 8'h5A);
    runVec("inv1D",    8'h1D, 10'h001, 1'b0, 8'h5A);
    runVec("idle",     8'h00, 10'h0FF, 1'b0, 8'h5A);
    runVec("accKeep",  8'h0F, 10'h000, 1'b1, 8'h33);

    // Async reset between edges while accumulating
    runVec("mid1", 8'h0D, 10'h005, 1'b1, 8'h38);
    runVec("mid2", 8'h0D, 10'h005, 1'b1, 8'h3D);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("asyncRst.dv", {7'b0, o_dv}, 8'h00);
    checkOutput("asyncRst.data", o_data, 8'h00);
    @(posedge sclk);
    #1;
    rst_n  = 1'b0;
    runVec("postRstAcc", 8'h0F, 10'h000, 1'b1, 8'h00);
    runVec("postRstSum", 8'h0D, 10'h021, 1'b1, 8'h21);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
